// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with configurable word length,
// parity and stop bits. Completed frames land in a one-entry valid/ready
// holding register together with their parity and framing flags; a frame
// that completes while the holding register is still occupied is dropped
// and reported with a one-cycle overrun pulse.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | line idle, waiting for a low level on the synced input
// S_START     | qualifying the start bit at its centre (glitch filter)
// S_DATA      | sampling data bits at mid-bit, LSB first
// S_PARITY    | sampling the parity bit (only when PARITY != 0)
// S_STOP      | sampling stop bit(s); the last one completes the frame
// S_WAIT_IDLE | line stuck low after a bad final stop bit, wait for high

module uart_rx_param #(
  parameter int CLKS_PER_BIT = 21812,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int IDX_W = $clog2(DATA_BITS);

  // Sample points: start bit is checked half a bit in, every later bit a
  // full bit period after the previous sample, i.e. at its centre.
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic             ODD_PAR  = (PARITY == 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  // Line synchroniser
  logic r_rx_meta;
  logic r_rxs;

  // Frame assembly
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr_acc;
  logic                 r_ferr_acc;

  // Holding register
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_overrun;

  // Frame completion strobe and final flag values on the completing cycle
  logic w_done;
  logic w_ferr;
  logic w_sample;

  assign w_sample = (r_cnt == FULL_M1);
  assign w_done   = (r_state == S_STOP) && w_sample && (r_stop_idx == LAST_STOP);
  assign w_ferr   = r_ferr_acc | ~r_rxs;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rxs     <= r_rx_meta;
    end
  end

  // Receive FSM: bit timing, data shifting and error accumulation
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_perr_acc <= 1'b0;
      r_ferr_acc <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end

        S_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (!r_rxs) begin
              r_state    <= S_DATA;
              r_idx      <= '0;
              r_perr_acc <= 1'b0;
              r_ferr_acc <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (w_sample) begin
            r_cnt   <= '0;
            // Right shift: after DATA_BITS samples the first line bit is bit 0
            r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
            if (r_idx == LAST_IDX) begin
              r_stop_idx <= 1'b0;
              if (PARITY != 0) r_state <= S_PARITY;
              else             r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_PARITY: begin
          if (w_sample) begin
            r_cnt      <= '0;
            r_perr_acc <= ((^r_shift) ^ r_rxs) != ODD_PAR;
            r_state    <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (w_sample) begin
            r_cnt <= '0;
            if (!r_rxs) r_ferr_acc <= 1'b1;
            if (r_stop_idx == LAST_STOP) begin
              // A low final stop bit means break or stuck line: do not rearm
              // until the line is seen high again.
              r_state <= r_rxs ? S_IDLE : S_WAIT_IDLE;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_WAIT_IDLE: begin
          if (r_rxs) r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Holding register: load on completion when free or being drained,
  // otherwise drop the new frame and flag overrun for one cycle
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_done) begin
        if (!r_valid || i_ready) begin
          r_data  <= r_shift;
          r_perr  <= r_perr_acc;
          r_ferr  <= w_ferr;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_parity_err = r_perr;
  assign o_frame_err  = r_ferr;
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: three instances (8N1, 8E1, 9N2) at 16 clocks
// per bit, directed scenarios followed by randomized frames checked against
// a frame-level reference model.

module tb_uart_rx_param;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Instance A: 8N1
  logic       rx_a = 1'b1, rdy_a = 1'b0;
  logic [7:0] data_a;
  logic       val_a, perr_a, ferr_a, ovr_a, busy_a;
  // Instance B: 8E1
  logic       rx_b = 1'b1, rdy_b = 1'b0;
  logic [7:0] data_b;
  logic       val_b, perr_b, ferr_b, ovr_b, busy_b;
  // Instance C: 9N2
  logic       rx_c = 1'b1, rdy_c = 1'b0;
  logic [8:0] data_c;
  logic       val_c, perr_c, ferr_c, ovr_c, busy_c;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .i_reset(rst), .i_rx(rx_a), .o_data(data_a), .o_valid(val_a),
    .i_ready(rdy_a), .o_parity_err(perr_a), .o_frame_err(ferr_a),
    .o_overrun(ovr_a), .o_busy(busy_a));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .i_reset(rst), .i_rx(rx_b), .o_data(data_b), .o_valid(val_b),
    .i_ready(rdy_b), .o_parity_err(perr_b), .o_frame_err(ferr_b),
    .o_overrun(ovr_b), .o_busy(busy_b));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .i_reset(rst), .i_rx(rx_c), .o_data(data_c), .o_valid(val_c),
    .i_ready(rdy_c), .o_parity_err(perr_c), .o_frame_err(ferr_c),
    .o_overrun(ovr_c), .o_busy(busy_c));

  int tests = 0;
  int fails = 0;

  // Overrun pulse counters, sampled away from the active edge
  int ov_cnt_a = 0, ov_cnt_b = 0, ov_cnt_c = 0;
  always @(negedge clk) begin
    if (ovr_a === 1'b1) ov_cnt_a++;
    if (ovr_b === 1'b1) ov_cnt_b++;
    if (ovr_c === 1'b1) ov_cnt_c++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic set_rdy(input int inst, input logic v);
    case (inst)
      0:       rdy_a = v;
      1:       rdy_b = v;
      default: rdy_c = v;
    endcase
  endtask

  // Serialise one frame bit by bit; caller is at a negedge
  task automatic send_frame(input int inst, input logic [8:0] d, input int nbits,
                            input int par, input bit flip, input int nstop,
                            input logic [1:0] stopv);
    logic q[$];
    logic pb;
    q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) q.push_back(d[i]);
    if (par != 0) begin
      pb = 1'b0;
      for (int i = 0; i < nbits; i++) pb = pb ^ d[i];
      if (par == 1) pb = ~pb;
      q.push_back(pb ^ flip);
    end
    for (int s = 0; s < nstop; s++) q.push_back(stopv[s]);
    foreach (q[i]) begin
      set_rx(inst, q[i]);
      repeat (CPB) @(negedge clk);
    end
    set_rx(inst, 1'b1);
  endtask

  // Reference model at frame level: what the receiver should report
  function automatic logic [31:0] model_data(input logic [8:0] d, input int nbits);
    return 32'(d) & ((32'd1 << nbits) - 1);
  endfunction

  function automatic logic model_perr(input logic [8:0] d, input int nbits,
                                      input int par, input bit flip);
    int ones;
    logic sent_pb;
    if (par == 0) return 1'b0;
    ones = $countones(model_data(d, nbits));
    // The bit the sender put on the line for this frame
    sent_pb = (par == 2) ? logic'(ones % 2) : logic'((ones + 1) % 2);
    sent_pb = sent_pb ^ flip;
    // Total ones including parity must be even (even) or odd (odd)
    return ((ones + int'(sent_pb)) % 2) != ((par == 1) ? 1 : 0);
  endfunction

  function automatic logic model_ferr(input int nstop, input logic [1:0] stopv);
    logic e = 1'b0;
    for (int s = 0; s < nstop; s++) if (stopv[s] == 1'b0) e = 1'b1;
    return e;
  endfunction

  task automatic check_frame(input string tag, input int inst, input logic [31:0] ed,
                             input logic ep, input logic ef);
    logic [31:0] d;
    logic v, p, f;
    case (inst)
      0:       begin d = 32'(data_a); v = val_a; p = perr_a; f = ferr_a; end
      1:       begin d = 32'(data_b); v = val_b; p = perr_b; f = ferr_b; end
      default: begin d = 32'(data_c); v = val_c; p = perr_c; f = ferr_c; end
    endcase
    check({tag, ".valid"}, 32'(v), 32'd1);
    check({tag, ".data"},  d, ed);
    check({tag, ".perr"},  32'(p), 32'(ep));
    check({tag, ".ferr"},  32'(f), 32'(ef));
  endtask

  task automatic consume(input string tag, input int inst);
    logic v;
    set_rdy(inst, 1'b1);
    @(negedge clk);
    set_rdy(inst, 1'b0);
    case (inst)
      0:       v = val_a;
      1:       v = val_b;
      default: v = val_c;
    endcase
    check({tag, ".drained"}, 32'(v), 32'd0);
  endtask

  initial begin
    logic [8:0] d;
    bit         flip;
    logic [1:0] sv;
    int         nb, pm, ns;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.valid_a", 32'(val_a), 32'd0);
    check("rst.data_a",  32'(data_a), 32'd0);
    check("rst.flags_a", {29'd0, perr_a, ferr_a, ovr_a}, 32'd0);
    check("rst.busy_a",  32'(busy_a), 32'd0);
    check("rst.valid_c", 32'(val_c), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1. 8N1, 0xA5 held while not ready, then drained
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11);
    repeat (4) @(negedge clk);
    check_frame("t1", 0, 32'hA5, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check_frame("t1.hold", 0, 32'hA5, 1'b0, 1'b0);
    check("t1.busy", 32'(busy_a), 32'd0);
    consume("t1", 0);
    check("t1.data_kept", 32'(data_a), 32'hA5);

    // 2. Even parity: correct then flipped parity bit
    send_frame(1, 9'h003, 8, 2, 1'b0, 1, 2'b11);
    repeat (4) @(negedge clk);
    check_frame("t2.good", 1, 32'h03, 1'b0, 1'b0);
    consume("t2.good", 1);
    send_frame(1, 9'h003, 8, 2, 1'b1, 1, 2'b11);
    repeat (4) @(negedge clk);
    check_frame("t2.bad", 1, 32'h03, 1'b1, 1'b0);
    consume("t2.bad", 1);

    // 3. Start-bit glitch rejected, following frame received
    rx_a = 1'b0;
    repeat (5) @(negedge clk);
    rx_a = 1'b1;
    repeat (30) @(negedge clk);
    check("t3.busy", 32'(busy_a), 32'd0);
    check("t3.valid", 32'(val_a), 32'd0);
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 2'b11);
    repeat (4) @(negedge clk);
    check_frame("t3", 0, 32'h5A, 1'b0, 1'b0);
    consume("t3", 0);

    // 4. Break: one frame with framing error, then nothing until line high
    rx_a = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    check_frame("t4", 0, 32'h00, 1'b0, 1'b1);
    consume("t4", 0);
    repeat (3 * 10 * CPB) @(negedge clk);
    check("t4.no_second", 32'(val_a), 32'd0);
    check("t4.wait_busy", 32'(busy_a), 32'd1);
    rx_a = 1'b1;
    repeat (6) @(negedge clk);
    check("t4.idle", 32'(busy_a), 32'd0);
    check("t4.no_ovr", 32'(ov_cnt_a), 32'd0);

    // 5. Overrun: second frame dropped, first held unchanged
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 2'b11);
    check("t5.no_ovr_yet", 32'(ov_cnt_a), 32'd0);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1, 2'b11);
    repeat (4) @(negedge clk);
    check_frame("t5", 0, 32'h11, 1'b0, 1'b0);
    check("t5.ovr_once", 32'(ov_cnt_a), 32'd1);
    check("t5.ovr_low", 32'(ovr_a), 32'd0);

    // 6. Reset in the middle of a 9N2 data phase, then 0x1FF
    rx_c = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_c = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("t6.busy_before", 32'(busy_c), 32'd1);
    rst = 1'b1;
    #1;
    check("t6.busy_rst", 32'(busy_c), 32'd0);
    check("t6.valid_rst", 32'(val_c), 32'd0);
    check("t6.a_cleared", {23'd0, val_a, data_a}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t6.no_frame", 32'(val_c), 32'd0);
    send_frame(2, 9'h1FF, 9, 0, 1'b0, 2, 2'b11);
    repeat (4) @(negedge clk);
    check_frame("t6", 2, 32'h1FF, 1'b0, 1'b0);
    consume("t6", 2);

    // 7. Random frames on every configuration against the model
    for (int n = 0; n < 18; n++) begin
      int inst;
      inst = n % 3;
      nb   = (inst == 2) ? 9 : 8;
      pm   = (inst == 1) ? 2 : 0;
      ns   = (inst == 2) ? 2 : 1;
      d    = 9'($urandom_range(511));
      flip = ($urandom_range(1) == 1);
      sv   = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
      send_frame(inst, d, nb, pm, flip, ns, sv);
      repeat (6) @(negedge clk);
      check_frame($sformatf("rnd%0d", n), inst, model_data(d, nb),
                  model_perr(d, nb, pm, flip), model_ferr(ns, sv));
      consume($sformatf("rnd%0d", n), inst);
    end
    check("end.ovr_b", 32'(ov_cnt_b), 32'd0);
    check("end.ovr_c", 32'(ov_cnt_c), 32'd0);
    check("end.ovr_a", 32'(ov_cnt_a), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
